// File: rtl/fadd_sequencer.sv
// Pushbutton-driven operand/compute sequencer for a half-precision adder.
// Optional FADD_ACCUM_EN: the result is also written back into operand A (running accumulate).
module fadd_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int LAT         = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        key2_i,
    input  logic        key3_i,
    input  logic        key4_i,
    input  logic [15:0] out_i,
    input  logic        trig_i,
    input  logic [15:0] result_i,
    output logic [15:0] opA_o,
    output logic [15:0] opB_o,
    output logic [15:0] displayValue_o,
    output logic [1:0]  mode_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHOW_A  = 3'd1,
        SHOW_B  = 3'd2,
        COMPUTE = 3'd3,
        SHOW_R  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] opA_q, opA_d;
    logic [15:0] opB_q, opB_d;
    logic [15:0] r_q, r_d;
    logic [3:0]  counter_q, counter_d;

    logic [2:0]                  keyRaw;
    logic [2:0][SYNC_STAGES-1:0] keySync_q;
    logic [SYNC_STAGES-1:0]      syncValid_q;
    logic [2:0]                  keyPrev_q;
    logic [2:0]                  keyArmed_q;
    logic [2:0]                  press;

    assign keyRaw = {key4_i, key3_i, key2_i};

    // A key is armed only after a genuinely sampled released level has reached the
    // synchronizer output, so a key held through reset release never produces a press.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            keySync_q   <= '1;
            syncValid_q <= '0;
            keyPrev_q   <= '1;
            keyArmed_q  <= '0;
        end else begin
            syncValid_q <= {syncValid_q[SYNC_STAGES-2:0], 1'b1};
            for (int k = 0; k < 3; k++) begin
                keySync_q[k]  <= {keySync_q[k][SYNC_STAGES-2:0], keyRaw[k]};
                keyPrev_q[k]  <= keySync_q[k][SYNC_STAGES-1];
                keyArmed_q[k] <= keyArmed_q[k] |
                                 (syncValid_q[SYNC_STAGES-1] & keySync_q[k][SYNC_STAGES-1]);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            press[k] = keyArmed_q[k] & keyPrev_q[k] & ~keySync_q[k][SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            opA_q     <= 16'h0000;
            opB_q     <= 16'h0000;
            r_q       <= 16'h0000;
            counter_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            r_q       <= r_d;
            counter_q <= counter_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        opA_d          = opA_q;
        opB_d          = opB_q;
        r_d            = r_q;
        counter_d      = counter_q;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        mode_o         = 2'd0;
        displayValue_o = out_i;

        case (state_q)
            COMPUTE: begin
                busy_o = 1'b1;
                if (counter_q == 4'd0) begin
                    done_o  = 1'b1;
                    r_d     = result_i;
`ifdef FADD_ACCUM_EN
                    opA_d   = result_i;
`endif
                    state_d = SHOW_R;
                end else begin
                    counter_d = counter_q - 4'd1;
                end
            end
            IDLE, SHOW_A, SHOW_B, SHOW_R: begin
                if (state_q == SHOW_A) begin
                    mode_o         = 2'd1;
                    displayValue_o = opA_q;
                end else if (state_q == SHOW_B) begin
                    mode_o         = 2'd2;
                    displayValue_o = opB_q;
                end else if (state_q == SHOW_R) begin
                    mode_o         = 2'd3;
                    displayValue_o = r_q;
                end

                // Priority KEY2 > KEY3 > KEY4 > Trig; losers in the same cycle are dropped.
                if (press[0]) begin
                    opA_d   = out_i;
                    state_d = SHOW_A;
                end else if (press[1]) begin
                    opB_d   = out_i;
                    state_d = SHOW_B;
                end else if (press[2]) begin
                    counter_d = 4'(LAT);
                    state_d   = COMPUTE;
                end else if (trig_i && state_q != IDLE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign opA_o = opA_q;
    assign opB_o = opB_q;

endmodule

// File: tb/tb_fadd_sequencer.sv
// Directed self-checking bench for fadd_sequencer; honours FADD_ACCUM_EN if defined.
module tb_fadd_sequencer;

    localparam int LAT = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key2, key3, key4;
    logic [15:0] outVal;
    logic        trig;
    logic [15:0] result;
    logic [15:0] opA, opB, displayValue;
    logic [1:0]  mode;
    logic        busy, done;

    int compared   = 0;
    int mismatched = 0;
    int busyCnt    = 0;
    int doneCnt    = 0;
    int busyBase, doneBase;
    logic [15:0] expR2, expA1;

    fadd_sequencer #(.SYNC_STAGES(2), .LAT(LAT)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .key2_i         (key2),
        .key3_i         (key3),
        .key4_i         (key4),
        .out_i          (outVal),
        .trig_i         (trig),
        .result_i       (result),
        .opA_o          (opA),
        .opB_o          (opB),
        .displayValue_o (displayValue),
        .mode_o         (mode),
        .busy_o         (busy),
        .done_o         (done)
    );

    always #5 clk = ~clk;

    // Stand-in for the half-precision adder: just the sums this bench needs.
    function automatic logic [15:0] halfAdd(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            {16'h3C00, 16'h4000}: halfAdd = 16'h4200;
            {16'h3C00, 16'h3C00}: halfAdd = 16'h4000;
            {16'h4000, 16'h3C00}: halfAdd = 16'h4200;
            default:              halfAdd = 16'h0000;
        endcase
    endfunction

    assign result = halfAdd(opA, opB);

    always @(negedge clk) begin
        if (busy) busyCnt++;
        if (done) doneCnt++;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h required %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int keyNum, input int holdCycles);
        if (keyNum == 2) key2 = 1'b0;
        if (keyNum == 3) key3 = 1'b0;
        if (keyNum == 4) key4 = 1'b0;
        waitCycles(holdCycles);
        key2 = 1'b1;
        key3 = 1'b1;
        key4 = 1'b1;
        waitCycles(LAT + 8);
    endtask

    initial begin
        rst_n  = 1'b0;
        key2   = 1'b1;
        key3   = 1'b1;
        key4   = 1'b1;
        trig   = 1'b0;
        outVal = 16'h1234;
        #2;
        checkOutput("reset opA", opA, 16'h0000);
        checkOutput("reset opB", opB, 16'h0000);
        checkOutput("reset mode", {14'd0, mode}, 16'd0);
        checkOutput("reset busy", {15'd0, busy}, 16'd0);
        checkOutput("reset done", {15'd0, done}, 16'd0);
        checkOutput("reset display", displayValue, 16'h1234);
        @(posedge clk); #1;
        rst_n = 1'b1;
        waitCycles(6);

        outVal = 16'h3C00;
        applyStimulus(2, 4);
        checkOutput("loadA opA", opA, 16'h3C00);
        checkOutput("loadA mode", {14'd0, mode}, 16'd1);
        checkOutput("loadA display", displayValue, 16'h3C00);

        outVal = 16'h4000;
        applyStimulus(3, 4);
        checkOutput("loadB opB", opB, 16'h4000);
        checkOutput("loadB mode", {14'd0, mode}, 16'd2);
        checkOutput("loadB display", displayValue, 16'h4000);
        checkOutput("loadB opA kept", opA, 16'h3C00);

        busyBase = busyCnt;
        doneBase = doneCnt;
        applyStimulus(4, 4);
        checkOutput("add busy cycles", 16'(busyCnt - busyBase), 16'(LAT + 1));
        checkOutput("add done pulses", 16'(doneCnt - doneBase), 16'd1);
        checkOutput("add display", displayValue, 16'h4200);
        checkOutput("add mode", {14'd0, mode}, 16'd3);

        outVal = 16'h1111;
        trig   = 1'b1;
        waitCycles(1);
        trig   = 1'b0;
        waitCycles(1);
        checkOutput("trig showR mode", {14'd0, mode}, 16'd0);
        checkOutput("trig showR display", displayValue, 16'h1111);
        trig = 1'b1;
        waitCycles(1);
        trig = 1'b0;
        outVal = 16'h2222;
        waitCycles(1);
        checkOutput("trig idle mode", {14'd0, mode}, 16'd0);
        checkOutput("trig idle display", displayValue, 16'h2222);

        outVal = 16'h4400;
        key2   = 1'b0;
        key3   = 1'b0;
        waitCycles(4);
        key2 = 1'b1;
        key3 = 1'b1;
        waitCycles(8);
        checkOutput("simul opA", opA, 16'h4400);
        checkOutput("simul opB", opB, 16'h4000);
        checkOutput("simul mode", {14'd0, mode}, 16'd1);

        outVal = 16'h5000;
        key2   = 1'b0;
        waitCycles(6);
        outVal = 16'h5555;
        waitCycles(94);
        checkOutput("held key2 single load", opA, 16'h5000);
        key2 = 1'b1;
        waitCycles(8);
        checkOutput("held key2 release", opA, 16'h5000);

        outVal = 16'h3C00;
        applyStimulus(2, 4);
        applyStimulus(3, 4);
        outVal = 16'h7777;
        key4   = 1'b0;
        waitCycles(2);
        key3   = 1'b0;
        waitCycles(4);
        @(negedge clk);
        checkOutput("compute busy", {15'd0, busy}, 16'd1);
        checkOutput("compute mode", {14'd0, mode}, 16'd0);
        checkOutput("compute display", displayValue, 16'h7777);
        waitCycles(2);
        key3 = 1'b1;
        key4 = 1'b1;
        waitCycles(LAT + 8);
        checkOutput("key3 in compute opB", opB, 16'h3C00);
        checkOutput("first R mode", {14'd0, mode}, 16'd3);
        checkOutput("first R display", displayValue, 16'h4000);
`ifdef FADD_ACCUM_EN
        expA1 = 16'h4000;
        expR2 = 16'h4200;
`else
        expA1 = 16'h3C00;
        expR2 = 16'h4000;
`endif
        checkOutput("opA after first R", opA, expA1);
        applyStimulus(4, 4);
        checkOutput("second R display", displayValue, expR2);

        outVal = 16'h0000;
        key4   = 1'b0;
        begin : waitBusy
            for (int i = 0; i < 30; i++) begin
                if (busy) disable waitBusy;
                waitCycles(1);
            end
        end
        checkOutput("abort reached compute", {15'd0, busy}, 16'd1);
        doneBase = doneCnt;
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", {15'd0, busy}, 16'd0);
        checkOutput("abort done", {15'd0, done}, 16'd0);
        checkOutput("abort opA", opA, 16'h0000);
        checkOutput("abort opB", opB, 16'h0000);
        checkOutput("abort mode", {14'd0, mode}, 16'd0);
        checkOutput("abort display", displayValue, 16'h0000);
        waitCycles(2);
        rst_n    = 1'b1;
        busyBase = busyCnt;
        waitCycles(20);
        key4 = 1'b1;
        waitCycles(10);
        checkOutput("held key4 no compute", 16'(busyCnt - busyBase), 16'd0);
        checkOutput("abort no done", 16'(doneCnt - doneBase), 16'd0);
        checkOutput("held key4 mode", {14'd0, mode}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fadd_sequencer.md
FADD_SEQUENCER -- requirements
Module: fadd_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for KEY2/KEY3/KEY4 (legal 2..4).
REQ-002 SHALL have parameter LAT, default 1: cycles from operand-stable to adder-result-valid (legal 1..15).
REQ-003 Clock  input  1  single clock; all state on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 KEY2  input  1  raw active-low pushbutton: load operand A.
REQ-006 KEY3  input  1  raw active-low pushbutton: load operand B.
REQ-007 KEY4  input  1  raw active-low pushbutton: start add.
REQ-008 Out  input  16  current keypad entry value (half-precision bits).
REQ-009 Trig  input  1  one-cycle pulse, new keypad digit accepted.
REQ-010 Result  input  16  sum from floatAdder (combinational from OpA/OpB).
REQ-011 OpA  output  16  registered operand A to floatAdder.
REQ-012 OpB  output  16  registered operand B to floatAdder.
REQ-013 displayValue  output  16  value routed to 7-segment controller.
REQ-014 mode  output  2  0 entry, 1 show A, 2 show B, 3 show R.
REQ-015 Busy  output  1  high while state = COMPUTE.
REQ-016 Done  output  1  one-cycle pulse when R is captured.

Function
REQ-017 Each KEYn SHALL pass through SYNC_STAGES flops (reset value 1), then falling-edge detect to a one-cycle press pulse; held key yields exactly one pulse.
REQ-018 FSM states SHALL be IDLE, SHOW_A, SHOW_B, COMPUTE, SHOW_R.
REQ-019 In any state except COMPUTE: KEY2 pulse -> OpA<=Out, state SHOW_A; KEY3 pulse -> OpB<=Out, state SHOW_B; KEY4 pulse -> state COMPUTE, counter<=LAT.
REQ-020 Simultaneous pulses SHALL resolve KEY2 > KEY3 > KEY4; lower-priority pulses that cycle are discarded.
REQ-021 In COMPUTE, counter SHALL decrement each cycle; all key pulses and Trig ignored.
REQ-022 When counter reaches 0 in COMPUTE: R_reg<=Result, Done=1 that cycle, state SHOW_R next cycle; total latency KEY4 pulse -> Done = LAT+1 cycles.
REQ-023 In SHOW_R or SHOW_A or SHOW_B, a Trig pulse (with no key pulse) SHALL return to IDLE; in IDLE Trig has no effect.
REQ-024 displayValue SHALL be Out in IDLE and COMPUTE, OpA in SHOW_A, OpB in SHOW_B, R_reg in SHOW_R.
REQ-025 mode SHALL be 0 in IDLE/COMPUTE, 1 SHOW_A, 2 SHOW_B, 3 SHOW_R.
REQ-026 OpA/OpB SHALL not change during COMPUTE.
REQ-027 Unreachable state encodings SHALL return to IDLE next cycle.

Reset
REQ-028 Reset low SHALL immediately force: state IDLE, OpA=OpB=R_reg=16'h0000, counter=0, Busy=0, Done=0, mode=0, synchronizer flops=1.
REQ-029 Reset asserted during COMPUTE SHALL abort with no Done pulse; no press pulse SHALL be generated on the first cycle after release even if a key is held.

Configuration
REQ-030 Macro FADD_ACCUM_EN: when defined, the Done cycle SHALL also load OpA<=Result, so the next KEY4 computes R+B (running accumulate).
REQ-031 When FADD_ACCUM_EN is undefined, OpA SHALL change only on KEY2 pulse or reset.

Verification
REQ-032 Out=3C00, KEY2 press; Out=4000, KEY3 press; KEY4 press -> Busy high LAT+1 cycles, Done pulse once, displayValue=4200, mode=3.
REQ-033 KEY2 and KEY3 asserted same cycle with Out=4400 -> OpA=4400, OpB unchanged, mode=1.
REQ-034 KEY2 held low 100 cycles -> exactly one OpA load; KEY3 press during COMPUTE -> OpB unchanged, no mode change.
REQ-035 Reset pulsed low mid-COMPUTE -> all outputs 0 immediately, no Done pulse; KEY4 held through release -> no COMPUTE entry.
REQ-036 With FADD_ACCUM_EN: A=3C00, B=3C00, KEY4 twice -> first R=4000, second R=4200; without macro second R=4000.
REQ-037 In SHOW_R, Trig pulse -> mode=0, displayValue follows Out.
